// File: rtl/serial_adder_ctrl_if.sv
// Requester-side handshake and operand/result bundle for serial_adder_ctrl.
// The optional "sub" request bit exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;

    // Requester side: issues operands and start, observes results.
    modport master (
        output start, a, b,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  sum, cout, busy, done
    );

    // Adder side: consumes the request, produces results.
    modport slave (
        input  start, a, b,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output sum, cout, busy, done
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full adder (two half adders plus OR) is reused
// LSB first over WIDTH clocks, with a carry flip-flop linking consecutive bits.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a "sub" request bit that
// computes a-b (B inverted on load, carry seeded with 1; cout=1 means no borrow).
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sub_req;
    logic             ha1_s, ha1_c;
    logic             ha2_s, ha2_c;
    logic             fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_req = bus.sub;
`else
    assign sub_req = 1'b0;
`endif

    // Shared adder cell: two half adders and an OR form the full adder.
    always_comb begin
        ha1_s = a_sh_q[0] ^ b_sh_q[0];
        ha1_c = a_sh_q[0] & b_sh_q[0];
        ha2_s = ha1_s ^ carry_q;
        ha2_c = ha1_s & carry_q;
        fa_c  = ha1_c | ha2_c;
    end

    // Sequencer next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = sub_req ? ~bus.b : bus.b;
                    carry_d = sub_req;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                carry_d = fa_c;
                sum_d   = {ha2_s, sum_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // done is registered from the DONE state, so busy is stretched to cover
        // the cycle in which the done pulse is visible.
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    // State and datapath registers; async reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
